// File: rtl/lut_loader.sv
// Branch-target table loader: streams (label, target) records into a label-indexed table
// with a combinational lookup port. Define LUT_LOADER_CKSUM_EN for a per-record checksum byte.
module lut_loader #(
    parameter int unsigned LBL_W = 8,
    parameter int unsigned PC_W  = 12,
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic [LBL_W-1:0] label,
    output logic [PC_W-1:0]  next_pc,
    output logic             busy,
    output logic             done,
`ifdef LUT_LOADER_CKSUM_EN
    output logic [7:0]       err_count,
`endif
    output logic [CNT_W-1:0] entry_count
);

    localparam int unsigned DEPTH = 2 ** LBL_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LBL  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
`ifdef LUT_LOADER_CKSUM_EN
    localparam logic [2:0] S_CK   = 3'd6;
`endif

    logic [2:0]       state_q, state_d;
    logic [LBL_W-1:0] lbl_q, lbl_d;
    logic [3:0]       nib_q, nib_d;
    logic             end_q, end_d;
    logic [7:0]       lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;
    logic [PC_W-1:0]  wr_data;
    logic [PC_W-1:0]  lut_q [DEPTH];
`ifdef LUT_LOADER_CKSUM_EN
    logic [7:0]       ck_q, ck_d;
    logic [7:0]       err_q, err_d;
`endif

    assign wr_data = PC_W'({nib_q, lo_q});

    // State and record-field registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lbl_q   <= '0;
            nib_q   <= '0;
            end_q   <= 1'b0;
            lo_q    <= '0;
            cnt_q   <= '0;
`ifdef LUT_LOADER_CKSUM_EN
            ck_q    <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lbl_q   <= lbl_d;
            nib_q   <= nib_d;
            end_q   <= end_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
`ifdef LUT_LOADER_CKSUM_EN
            ck_q    <= ck_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and output decode; outputs depend on state_q only
    always_comb begin
        state_d  = state_q;
        lbl_d    = lbl_q;
        nib_d    = nib_q;
        end_d    = end_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
`ifdef LUT_LOADER_CKSUM_EN
        ck_d     = ck_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    state_d = S_LBL;
                    cnt_d   = '0;
`ifdef LUT_LOADER_CKSUM_EN
                    err_d   = '0;
`endif
                end
            end
            S_LBL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    lbl_d   = LBL_W'(in_data);
                    state_d = S_HI;
`ifdef LUT_LOADER_CKSUM_EN
                    ck_d    = in_data;
`endif
                end
            end
            S_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    nib_d   = in_data[3:0];
                    end_d   = in_data[7];
                    state_d = S_LO;
`ifdef LUT_LOADER_CKSUM_EN
                    ck_d    = ck_q ^ in_data;
`endif
                end
            end
            S_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    lo_d    = in_data;
`ifdef LUT_LOADER_CKSUM_EN
                    ck_d    = ck_q ^ in_data;
                    state_d = S_CK;
`else
                    state_d = S_WR;
`endif
                end
            end
`ifdef LUT_LOADER_CKSUM_EN
            S_CK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (in_data == ck_q) begin
                        state_d = S_WR;
                    end else begin
                        err_d   = (&err_q) ? err_q : err_q + 8'd1;
                        state_d = end_q ? S_DONE : S_LBL;
                    end
                end
            end
`endif
            S_WR: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                state_d = end_q ? S_DONE : S_LBL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Target table; reset clears every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) lut_q[i] <= '0;
        end else if (wr_en) begin
            lut_q[lbl_q] <= wr_data;
        end
    end

    assign next_pc     = lut_q[label];
    assign entry_count = cnt_q;
`ifdef LUT_LOADER_CKSUM_EN
    assign err_count   = err_q;
`endif

endmodule

// File: tb/tb_lut_loader.sv
// Scoreboard bench for lut_loader: stimulus queues expected values, a negedge monitor compares.
module tb_lut_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  label;
    logic [11:0] next_pc;
    logic        busy;
    logic        done;
    logic [8:0]  entry_count;
`ifdef LUT_LOADER_CKSUM_EN
    logic [7:0]  err_count;
`endif

    lut_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .label       (label),
        .next_pc     (next_pc),
        .busy        (busy),
        .done        (done),
`ifdef LUT_LOADER_CKSUM_EN
        .err_count   (err_count),
`endif
        .entry_count (entry_count)
    );

    localparam int unsigned ID_PC = 0, ID_RDY = 1, ID_BUSY = 2, ID_DONE = 3,
                            ID_CNT = 4, ID_ERR = 5, ID_TMO = 6;

    typedef struct {
        int unsigned id;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t        sb_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned timeouts = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] actual(input int unsigned id);
        case (id)
            ID_PC:   return 16'(next_pc);
            ID_RDY:  return 16'(in_ready);
            ID_BUSY: return 16'(busy);
            ID_DONE: return 16'(done);
            ID_CNT:  return 16'(entry_count);
`ifdef LUT_LOADER_CKSUM_EN
            ID_ERR:  return 16'(err_count);
`endif
            ID_TMO:  return 16'(timeouts);
            default: return 16'hdead;
        endcase
    endfunction

    // Monitor: drain all pending expectations at each falling edge
    always @(negedge clk) begin
        chk_t c;
        logic [15:0] a;
        while (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            a = actual(c.id);
            vectors++;
            if (a !== c.exp) begin
                miscompares++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, a, c.exp);
            end
        end
    end

    task automatic expect_sig(input int unsigned id, input logic [15:0] e, input string n);
        chk_t c;
        c.id = id; c.exp = e; c.name = n;
        sb_q.push_back(c);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input logic [7:0] l, input logic [15:0] e, input string n);
        label = l;
        #1;
        expect_sig(ID_PC, e, n);
        settle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int unsigned n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 64);
        if (!acc) timeouts++;
    endtask

    task automatic gap(input int unsigned g);
        if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) step();
        end
    endtask

    // Sends one full record; returns one cycle into S_WR with in_valid still high
    task automatic send_record(input logic [7:0] l, input logic [7:0] h,
                               input logic [7:0] lo, input int unsigned g);
        send_byte(l);  gap(g);
        send_byte(h);  gap(g);
        send_byte(lo);
`ifdef LUT_LOADER_CKSUM_EN
        gap(g);
        send_byte(l ^ h ^ lo);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; label = 8'h05;
        repeat (2) step();

        // Reset state
        expect_sig(ID_PC,   16'h000, "reset_next_pc");
        expect_sig(ID_RDY,  16'h0,   "reset_in_ready");
        expect_sig(ID_BUSY, 16'h0,   "reset_busy");
        expect_sig(ID_DONE, 16'h0,   "reset_done");
        expect_sig(ID_CNT,  16'h0,   "reset_entry_count");
`ifdef LUT_LOADER_CKSUM_EN
        expect_sig(ID_ERR,  16'h0,   "reset_err_count");
`endif
        settle();
        step();
        reset = 1'b0;

        // Single record
        pulse_start();
        expect_sig(ID_BUSY, 16'h1, "start_busy");
        expect_sig(ID_RDY,  16'h1, "start_in_ready");
        settle();
        label = 8'h02;
        send_record(8'h02, 8'h81, 8'h60, 0);
        in_valid = 1'b0;
        expect_sig(ID_RDY,  16'h0,   "single_wr_in_ready");
        expect_sig(ID_BUSY, 16'h1,   "single_wr_busy");
        expect_sig(ID_PC,   16'h000, "single_wr_old_value");
        settle();
        step();
        expect_sig(ID_PC,   16'h160, "single_next_pc");
        expect_sig(ID_DONE, 16'h1,   "single_done");
        expect_sig(ID_BUSY, 16'h0,   "single_busy");
        expect_sig(ID_CNT,  16'h1,   "single_entry_count");
        expect_sig(ID_RDY,  16'h0,   "single_done_in_ready");
        settle();

        // Multi-record with stalls
        pulse_start();
        send_record(8'h03, 8'h00, 8'hD0, 2);
        in_valid = 1'b0;
        step();
        send_record(8'h10, 8'h01, 8'hEA, 1);
        in_valid = 1'b0;
        expect_sig(ID_RDY, 16'h0, "multi_wr_in_ready");
        settle();
        step();
        expect_sig(ID_RDY, 16'h1, "multi_stall_in_ready");
        expect_sig(ID_CNT, 16'h2, "multi_mid_entry_count");
        settle();
        send_record(8'h11, 8'h82, 8'h71, 3);
        in_valid = 1'b0;
        step();
        expect_sig(ID_DONE, 16'h1, "multi_done");
        expect_sig(ID_RDY,  16'h0, "multi_done_in_ready");
        expect_sig(ID_CNT,  16'h3, "multi_entry_count");
        settle();
        chk_pc(8'h03, 16'h0D0, "multi_pc_03");
        chk_pc(8'h10, 16'h1EA, "multi_pc_10");
        chk_pc(8'h11, 16'h271, "multi_pc_11");
        chk_pc(8'h02, 16'h160, "persist_pc_02");
        chk_pc(8'h7F, 16'h000, "unwritten_pc_7f");

        // Write/read collision, then duplicate label in the same session
        label = 8'h03;
        pulse_start();
        send_record(8'h03, 8'h00, 8'hFF, 0);
        in_valid = 1'b0;
        expect_sig(ID_PC, 16'h0D0, "collide_old_value");
        settle();
        step();
        expect_sig(ID_PC, 16'h0FF, "collide_new_value");
        settle();
        send_record(8'h03, 8'h80, 8'hAB, 0);
        in_valid = 1'b0;
        step();
        expect_sig(ID_PC,   16'h0AB, "dup_last_wins");
        expect_sig(ID_CNT,  16'h2,   "dup_entry_count");
        expect_sig(ID_DONE, 16'h1,   "dup_done");
        settle();

        // Reset mid-record
        pulse_start();
        send_byte(8'h05);
        send_byte(8'h01);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        expect_sig(ID_RDY,  16'h0, "midreset_in_ready");
        expect_sig(ID_BUSY, 16'h0, "midreset_busy");
        expect_sig(ID_DONE, 16'h0, "midreset_done");
        expect_sig(ID_CNT,  16'h0, "midreset_entry_count");
        settle();
        chk_pc(8'h03, 16'h000, "midreset_pc_03");
        chk_pc(8'h02, 16'h000, "midreset_pc_02");
        step();
        reset = 1'b0;
        pulse_start();
        send_byte(8'h05);
        start = 1'b1;
        send_byte(8'h81);
        start = 1'b0;
        send_byte(8'h34);
`ifdef LUT_LOADER_CKSUM_EN
        send_byte(8'h05 ^ 8'h81 ^ 8'h34);
`endif
        in_valid = 1'b0;
        step();
        expect_sig(ID_DONE, 16'h1, "reload_done");
        expect_sig(ID_CNT,  16'h1, "reload_entry_count");
        settle();
        chk_pc(8'h05, 16'h134, "reload_pc_05");
        chk_pc(8'h03, 16'h000, "reload_pc_03");

`ifdef LUT_LOADER_CKSUM_EN
        // Checksum mismatch then match
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h80);
        send_byte(8'hDD);
        send_byte(8'h00);
        in_valid = 1'b0;
        expect_sig(ID_DONE, 16'h1, "ck_bad_done");
        expect_sig(ID_ERR,  16'h1, "ck_bad_err_count");
        expect_sig(ID_CNT,  16'h0, "ck_bad_entry_count");
        settle();
        chk_pc(8'h04, 16'h000, "ck_bad_no_write");
        pulse_start();
        expect_sig(ID_ERR, 16'h0, "ck_start_clears_err");
        settle();
        send_record(8'h04, 8'h80, 8'hDD, 0);
        in_valid = 1'b0;
        step();
        expect_sig(ID_DONE, 16'h1, "ck_good_done");
        expect_sig(ID_CNT,  16'h1, "ck_good_entry_count");
        expect_sig(ID_ERR,  16'h0, "ck_good_err_count");
        settle();
        chk_pc(8'h04, 16'h0DD, "ck_good_pc_04");
`endif

        expect_sig(ID_TMO, 16'h0, "handshake_timeouts");
        settle();
        settle();
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d expectations never checked", sb_q.size());
        end
        if (timeouts != 0) begin
            $display("FAIL handshake: %0d byte transfers timed out", timeouts);
        end
        if (vectors < 12) begin
            miscompares++;
            $display("FAIL coverage: only %0d vectors applied", vectors);
        end
        if (miscompares != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Writer side of the branch-target lookup: a programmable label -> next_pc table, loaded at boot from a byte stream, with a combinational lookup port for the fetch stage.
- Replaces hard-coded target constants: the assembler emits (label, target) records, the loader streams them in, and fetch reads next_pc by label exactly as before.
- Sits between the boot/program-load path (byte source) and the PC-next mux.

Parameters:
- LBL_W, 8, label width; table depth = 2**LBL_W.
- PC_W, 12, target width; must be <= 16.
- CNT_W, 9, width of entry_count (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears FSM, counters and the whole table.
- start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE or DONE).
- in_valid  in  1  byte-source valid.
- in_data  in  8  record byte.
- in_ready  out  1  loader accepts a byte this cycle; transfer = in_valid & in_ready.
- label  in  LBL_W  lookup index from fetch.
- next_pc  out  PC_W  table[label], combinational.
- busy  out  1  high from accepted start until entering DONE.
- done  out  1  high in DONE, until next start or reset.
- entry_count  out  CNT_W  number of table writes this session, saturates at all-ones.

Behaviour:
- Record format, one byte per transfer, in order: LABEL, HI, LO.
- HI[3:0] = target[11:8]; HI[7] = END flag; HI[6:4] ignored. For PC_W < 12, upper target bits are truncated.
- LO = target[7:0].
- Written target = {HI[3:0], LO}[PC_W-1:0].
- FSM states and transitions:
  - IDLE: in_ready=0. start -> S_LBL and entry_count cleared to 0.
  - S_LBL: in_ready=1. Transfer latches the label -> S_HI.
  - S_HI: in_ready=1. Transfer latches the target high nibble and END -> S_LO.
  - S_LO: in_ready=1. Transfer latches the low byte -> S_WR (S_CK when checksum enabled).
  - S_WR: in_ready=0, one cycle. Writes table[label_q] <= target at the rising edge ending this state and increments entry_count (saturating). Next state is DONE if END is set, else S_LBL.
  - DONE: in_ready=0, done=1. start -> S_LBL and entry_count cleared.
- Throughput: one record per 4 cycles when in_valid is held high; no combinational path from in_valid to in_ready.
- Stalls: in_valid low holds the current state indefinitely; latched bytes are kept.
- start outside IDLE/DONE is ignored; the session continues.
- Table contents persist across sessions. A new session overwrites only the labels it writes.
- Duplicate label in one session: last write wins; entry_count still counts every write.
- Lookup:
  - next_pc = table[label] combinationally, at any time, including mid-load.
  - A read of the label being written in S_WR returns the old value that cycle and the new value from the next cycle.
  - Unwritten entries read 0.
- Reset (async, any time, including mid-record):
  - State -> IDLE; in_ready=0, busy=0, done=0, entry_count=0.
  - All table entries = 0, so next_pc = 0.
  - A partial record is discarded.
  - The first start after reset release is honoured on the following edge.

Optional Feature:
- Macro: LUT_LOADER_CKSUM_EN.
- Enabled:
  - A fourth byte CK follows LO. State S_CK has in_ready=1.
  - Valid iff CK == LABEL ^ HI ^ LO.
  - Valid: -> S_WR as normal.
  - Mismatch: no table write, entry_count unchanged, err_count increments (saturating). END is still honoured: mismatch with END set -> DONE, else -> S_LBL.
  - Extra port err_count out 8, reset 0, cleared on an accepted start.
- Disabled: 3-byte records, no S_CK state, no err_count port.

Test Plan:
- Reset then idle: label=0x05 -> next_pc=0x000; in_ready=0, busy=0, done=0.
- Single record: start, bytes 0x02,0x81,0x60 with in_valid held -> S_WR four cycles after the first byte; label=0x02 gives next_pc=0x160; done=1, entry_count=1.
- Multi-record with stalls: records (0x03,0x00,0xD0),(0x10,0x01,0xEA),(0x11,0x82,0x71) with in_valid toggling -> 0x03->0x0D0, 0x10->0x1EA, 0x11->0x271; entry_count=3; in_ready low in S_WR and DONE.
- Write/read collision: hold label=0x03 during a rewrite to 0x0FF -> old value 0x0D0 during S_WR, 0x0FF on the next cycle. Duplicate label in the same session -> last value wins, entry_count=2.
- Reset mid-record: assert reset after LABEL,HI are accepted -> table cleared and state IDLE. A new start with a full record loads correctly; start pulsed mid-session is ignored.
- LUT_LOADER_CKSUM_EN defined:
  - Bad record 0x04,0x80,0xDD,0x00 -> no write (label 0x04 still 0), err_count=1, done=1.
  - Good record 0x04,0x80,0xDD,0x59 -> 0x04->0x0DD.
